// File: rtl/n_fish_ctrl.sv
// Purpose: owns the fish-count register and mirrors it into the n_fish PIO with coalesced, rate-limited writes.
// Latency: inc in cycle N -> count in N+1 -> PIO write strobe in N+2; strobes at least GAP_CYCLES+2 apart.
// Backpressure: none taken; updates are always accepted, and bursts collapse into one pending write of the latest count.
module n_fish_ctrl #(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int GAP_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr_req,
    input  logic             pre_req,
    input  logic [CNT_W-1:0] pre_val,
    output logic             clr_ack,
    output logic             pre_ack,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             busy,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wdata_q, wdata_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sat_q, sat_d;
    logic             dirty_q, dirty_d;
    logic             clr_hold_q, clr_hold_d;
    logic             pre_hold_q, pre_hold_d;

    logic clr_acc, pre_acc, inc_acc, upd;

    // Update arbitration: clear beats preset beats inc; an ack blocks the same request for one cycle.
    always_comb begin
        clr_acc    = clr_req && !clr_hold_q;
        pre_acc    = pre_req && !pre_hold_q && !clr_acc;
        inc_acc    = inc && !clr_acc && !pre_acc;
        upd        = clr_acc || pre_acc || inc_acc;
        clr_hold_d = clr_acc;
        pre_hold_d = pre_acc;
        count_d    = count_q;
        sat_d      = sat_q;
        if (clr_acc) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (pre_acc) begin
            count_d = pre_val;
            sat_d   = 1'b0;
        end else if (inc_acc) begin
            if (&count_q) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Write sequencer and pending-write flag. The write payload is captured on the IDLE->WRITE
    // transition, so dirty is retired at that same point; any update from then on re-arms it.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        wdata_d = wdata_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    state_d = WRITE;
                    wdata_d = count_q;
                    dirty_d = 1'b0;
                end
            end
            WRITE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (upd) begin
            dirty_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wdata_q    <= '0;
            gap_q      <= '0;
            sat_q      <= 1'b0;
            dirty_q    <= 1'b0;
            clr_hold_q <= 1'b0;
            pre_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            gap_q      <= gap_d;
            sat_q      <= sat_d;
            dirty_q    <= dirty_d;
            clr_hold_q <= clr_hold_d;
            pre_hold_q <= pre_hold_d;
        end
    end

    // Outputs; the PIO strobe decodes straight from the state flop so reset drops it at once.
    always_comb begin
        clr_ack        = clr_acc;
        pre_ack        = pre_acc;
        count          = count_q;
        sat            = sat_q;
        busy           = (state_q != IDLE) || dirty_q;
        pio_address    = 2'b00;
        pio_chipselect = (state_q == WRITE);
        pio_write_n    = (state_q != WRITE);
        pio_writedata  = 32'(wdata_q);
    end

endmodule

// File: tb/tb_n_fish_ctrl.sv
// Directed bench for n_fish_ctrl: reset, single inc, coalescing, preset/saturation, clear priority, ack hold-off, reset mid-write.
// Strobes are logged at the falling edge; inputs are driven 1 time unit after the rising edge.
// Every wait on the DUT is bounded and an expired bound counts as a failure.
module tb_n_fish_ctrl;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inc, clr_req, pre_req;
    logic [15:0] pre_val;
    logic        clr_ack, pre_ack, sat, busy;
    logic [15:0] count;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    n_fish_ctrl #(.CNT_W(16), .GAP_CYCLES(GAP), .GAP_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inc            (inc),
        .clr_req        (clr_req),
        .pre_req        (pre_req),
        .pre_val        (pre_val),
        .clr_ack        (clr_ack),
        .pre_ack        (pre_ack),
        .count          (count),
        .sat            (sat),
        .busy           (busy),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (pio_chipselect && !pio_write_n) begin
            w.c = cyc;
            w.d = pio_writedata;
            wq.push_back(w);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic do_clr();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_idle();
        wq.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; inc = 1'b0; clr_req = 1'b0; pre_req = 1'b0; pre_val = '0;
        repeat (3) tick();
        n_cmp++; if (count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0000", count); end
        n_cmp++; if (sat !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: sat=%b busy=%b want 0 0", sat, busy); end
        n_cmp++; if (clr_ack !== 1'b0 || pre_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: clr_ack=%b pre_ack=%b want 0 0", clr_ack, pre_ack); end
        n_cmp++; if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_pio: cs=%b wr_n=%b want 0 1", pio_chipselect, pio_write_n); end
        reset_n = 1'b1;
        repeat (8) tick();
        n_cmp++; if (wq.size() !== 0) begin n_fail++; $display("FAIL reset_no_write: got %0d strobes want 0", wq.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_inc();
        int t0;
        wq.delete();
        t0  = cyc;
        inc = 1'b1;
        tick();
        inc = 1'b0;
        n_cmp++; if (count !== 16'h0001) begin n_fail++; $display("FAIL single_count: got %h want 0001", count); end
        for (int k = 0; k < GAP + 8; k++) begin
            tick();
            if (cyc == t0 + 2 + GAP) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi: got %b want 1 at rel %0d", busy, cyc - t0); end
            end
            if (cyc == t0 + 3 + GAP) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_lo: got %b want 0 at rel %0d", busy, cyc - t0); end
            end
        end
        n_cmp++;
        if (wq.size() !== 1) begin
            n_fail++; $display("FAIL single_nwrites: got %0d want 1", wq.size());
        end else begin
            n_cmp++; if (wq[0].c !== t0 + 2) begin n_fail++; $display("FAIL single_write_cycle: got rel %0d want 2", wq[0].c - t0); end
            n_cmp++; if (wq[0].d !== 32'h0000_0001) begin n_fail++; $display("FAIL single_write_data: got %h want 00000001", wq[0].d); end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_clr();
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            inc = 1'b1;
            tick();
        end
        inc = 1'b0;
        n_cmp++; if (count !== 16'h0005) begin n_fail++; $display("FAIL b2b_count: got %h want 0005", count); end
        repeat (20) tick();
        n_cmp++;
        if (wq.size() !== 2) begin
            n_fail++; $display("FAIL b2b_nwrites: got %0d want 2", wq.size());
        end else begin
            n_cmp++; if (wq[0].d !== 32'h1) begin n_fail++; $display("FAIL b2b_first_data: got %h want 00000001", wq[0].d); end
            n_cmp++; if (wq[0].c !== t0 + 2) begin n_fail++; $display("FAIL b2b_first_cycle: got rel %0d want 2", wq[0].c - t0); end
            n_cmp++; if (wq[1].d !== 32'h5) begin n_fail++; $display("FAIL b2b_second_data: got %h want 00000005", wq[1].d); end
            n_cmp++; if (wq[1].c - wq[0].c !== GAP + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", wq[1].c - wq[0].c, GAP + 2); end
        end
    endtask

    task automatic test_preset_sat();
        do_clr();
        pre_val = 16'hFFFE;
        pre_req = 1'b1;
        #1;
        n_cmp++; if (pre_ack !== 1'b1) begin n_fail++; $display("FAIL pre_ack: got %b want 1", pre_ack); end
        tick();
        pre_req = 1'b0;
        n_cmp++; if (count !== 16'hFFFE) begin n_fail++; $display("FAIL pre_count: got %h want fffe", count); end
        for (int k = 0; k < 3; k++) begin
            inc = 1'b1;
            tick();
        end
        inc = 1'b0;
        n_cmp++; if (count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %h want ffff", count); end
        n_cmp++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", sat); end
        wait_idle();
        n_cmp++;
        if (wq.size() == 0) begin
            n_fail++; $display("FAIL sat_nwrites: got 0 want >0");
        end else if (wq[wq.size()-1].d !== 32'h0000_FFFF) begin
            n_fail++; $display("FAIL sat_last_data: got %h want 0000ffff", wq[wq.size()-1].d);
        end
        wq.delete();
        clr_req = 1'b1;
        #1;
        n_cmp++; if (clr_ack !== 1'b1) begin n_fail++; $display("FAIL clr_ack: got %b want 1", clr_ack); end
        tick();
        clr_req = 1'b0;
        #1;
        n_cmp++; if (clr_ack !== 1'b0) begin n_fail++; $display("FAIL clr_ack_pulse: got %b want 0", clr_ack); end
        n_cmp++; if (count !== 16'h0 || sat !== 1'b0) begin n_fail++; $display("FAIL clr_state: count=%h sat=%b want 0000 0", count, sat); end
        wait_idle();
        n_cmp++;
        if (wq.size() !== 1) begin
            n_fail++; $display("FAIL clr_nwrites: got %0d want 1", wq.size());
        end else if (wq[0].d !== 32'h0) begin
            n_fail++; $display("FAIL clr_write_data: got %h want 00000000", wq[0].d);
        end
    endtask

    task automatic test_clr_vs_inc();
        pre_val = 16'h0007;
        pre_req = 1'b1;
        tick();
        pre_req = 1'b0;
        wait_idle();
        wq.delete();
        n_cmp++; if (count !== 16'h0007) begin n_fail++; $display("FAIL cvi_setup: got %h want 0007", count); end
        clr_req = 1'b1;
        inc     = 1'b1;
        #1;
        n_cmp++; if (clr_ack !== 1'b1) begin n_fail++; $display("FAIL cvi_ack: got %b want 1", clr_ack); end
        tick();
        clr_req = 1'b0;
        inc     = 1'b0;
        n_cmp++; if (count !== 16'h0 || sat !== 1'b0) begin n_fail++; $display("FAIL cvi_count: count=%h sat=%b want 0000 0", count, sat); end
        wait_idle();
        n_cmp++;
        if (wq.size() !== 1) begin
            n_fail++; $display("FAIL cvi_nwrites: got %0d want 1", wq.size());
        end else if (wq[0].d !== 32'h0) begin
            n_fail++; $display("FAIL cvi_write_data: got %h want 00000000", wq[0].d);
        end
    endtask

    task automatic test_pre_hold();
        logic [2:0] acks;
        logic [2:0] want;
        want = 3'b101;
        wq.delete();
        pre_val = 16'h1234;
        pre_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            acks[k] = pre_ack;
            tick();
        end
        pre_req = 1'b0;
        n_cmp++; if (acks !== want) begin n_fail++; $display("FAIL pre_hold_acks: got %b want %b (bit0=first cycle)", acks, want); end
        n_cmp++; if (count !== 16'h1234) begin n_fail++; $display("FAIL pre_hold_count: got %h want 1234", count); end
        wait_idle();
        n_cmp++; if (wq.size() == 0) begin n_fail++; $display("FAIL pre_hold_nwrites: got 0 want >0"); end
        foreach (wq[i]) begin
            n_cmp++;
            if (wq[i].d !== 32'h0000_1234) begin n_fail++; $display("FAIL pre_hold_data[%0d]: got %h want 00001234", i, wq[i].d); end
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        do_clr();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        while (pio_write_n && n < 20) begin
            tick();
            n++;
        end
        n_cmp++; if (pio_write_n !== 1'b0) begin n_fail++; $display("FAIL rmw_strobe_seen: wr_n=%b want 0", pio_write_n); end
        n_cmp++; if (pio_address !== 2'b00 || pio_writedata !== 32'h1) begin n_fail++; $display("FAIL rmw_strobe_fields: addr=%b data=%h want 00 00000001", pio_address, pio_writedata); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pio_write_n !== 1'b1 || pio_chipselect !== 1'b0) begin n_fail++; $display("FAIL rmw_async_drop: wr_n=%b cs=%b want 1 0", pio_write_n, pio_chipselect); end
        n_cmp++; if (count !== 16'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmw_reset_state: count=%h busy=%b want 0000 0", count, busy); end
        #2;
        reset_n = 1'b1;
        wq.delete();
        repeat (15) tick();
        n_cmp++; if (wq.size() !== 0) begin n_fail++; $display("FAIL rmw_no_write: got %0d strobes want 0", wq.size()); end
        n_cmp++; if (count !== 16'h0) begin n_fail++; $display("FAIL rmw_count_after: got %h want 0000", count); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_back_to_back();
        test_preset_sat();
        test_clr_vs_inc();
        test_pre_hold();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
